// File: rtl/mux_n_1_pipe.sv
// rtl/mux_n_1_pipe.sv - N:1 operand-select mux feeding a registered two-entry skid-buffered valid/ready stage
module mux_n_1_pipe #(
    parameter int WIDTH = 64,
    parameter int N_IN  = 4,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_t;

    count_t           count, count_nxt;
    logic [WIDTH-1:0] main_q, skid_q, mux_data;
    logic             accept, drain;
    logic             load_main_mux, load_main_skid, load_skid;

    // Codes past the last lane fall through to zero.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (int'(sel) == k) mux_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    // Handshake flags come from the registered count only, so in_ready never sees out_ready.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign out_data  = main_q;

    always_comb begin
        count_nxt      = count;
        load_main_mux  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (count)
            EMPTY: begin
                if (accept) begin
                    count_nxt     = ONE;
                    load_main_mux = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main_mux = 1'b1;
                end else if (accept) begin
                    count_nxt = FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    count_nxt = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    count_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: count_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            count <= count_nxt;
            if (load_main_mux) begin
                main_q <= mux_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) skid_q <= mux_data;
        end
    end

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// tb/tb_mux_n_1_pipe.sv - randomized self-checking bench for mux_n_1_pipe against a queue model
module tb_mux_n_1_pipe;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, out_ready;
    logic [1:0]   sel;
    logic [255:0] in_data;
    logic         in_ready, out_valid;
    logic [63:0]  out_data;

    logic         reset3, flush3, in_valid3, out_ready3;
    logic [1:0]   sel3;
    logic [191:0] in_data3;
    logic         in_ready3, out_valid3;
    logic [63:0]  out_data3;

    int errors = 0;
    int checks = 0;

    logic [63:0] q[$];
    logic [63:0] last;

    always #5 clk = ~clk;

    mux_n_1_pipe #(.WIDTH(64), .N_IN(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    mux_n_1_pipe #(.WIDTH(64), .N_IN(3)) dut3 (
        .clk(clk), .reset(reset3), .flush(flush3),
        .in_valid(in_valid3), .in_ready(in_ready3), .sel(sel3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3)
    );

    function automatic logic [63:0] ref_sel(input int s, input logic [255:0] d, input int n);
        if (s >= n) return 64'h0;
        return d[s*64 +: 64];
    endfunction

    function automatic logic [63:0] exp_data();
        return (q.size() > 0) ? q[0] : last;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic randomize_in();
        sel = 2'($urandom_range(0, 3));
        for (int k = 0; k < 4; k++) in_data[k*64 +: 64] = rnd64();
    endtask

    // Advance one clock and update the reference FIFO (capacity two) from the handshakes.
    task automatic edge_step();
        bit acc, drn;
        logic [63:0] v;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        v   = ref_sel(int'(sel), in_data, 4);
        @(posedge clk);
        if (reset || flush) begin
            q.delete();
            last = 64'h0;
        end else begin
            if (drn) last = q.pop_front();
            if (acc) q.push_back(v);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; randomize_in();
        edge_step();
        reset = 1'b0; in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_single();
        randomize_in();
        in_valid = 1'b1; sel = 2'd2; in_data[2*64 +: 64] = 64'hDEAD_BEEF_0000_0002; out_ready = 1'b1;
        edge_step();
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%0b exp=1", out_valid); end
        if (out_data !== 64'hDEAD_BEEF_0000_0002) begin errors++; $display("FAIL single_out_data got=%h exp=deadbeef00000002", out_data); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%0b exp=1", in_ready); end
        edge_step();
    endtask

    task automatic test_full();
        logic [63:0] got[$];
        logic [63:0] want[3];
        bit take;
        want[0] = 64'h1; want[1] = 64'h4; want[2] = 64'h3;
        out_ready = 1'b0; in_valid = 1'b1;
        randomize_in(); sel = 2'd0; in_data[0 +: 64] = 64'h1;
        edge_step();
        randomize_in(); sel = 2'd3; in_data[3*64 +: 64] = 64'h4;
        edge_step();
        checks += 1;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
        randomize_in(); sel = 2'd1; in_data[64 +: 64] = 64'h3;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            checks += 2;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL full_c_blocked got=%0b exp=0", in_ready); end
            if (out_data !== 64'h1) begin errors++; $display("FAIL full_hold got=%h exp=1", out_data); end
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            checks += 3;
            if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL full_out_valid got=%0b exp=%0b", out_valid, q.size() > 0); end
            if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL full_in_ready_m got=%0b exp=%0b", in_ready, q.size() < 2); end
            if (out_data !== exp_data()) begin errors++; $display("FAIL full_out_data got=%h exp=%h", out_data, exp_data()); end
            if (out_valid && out_ready) got.push_back(out_data);
            take = in_valid && (q.size() < 2);
            edge_step();
            if (take) in_valid = 1'b0;
        end
        checks += 1;
        if (got.size() != 3) begin errors++; $display("FAIL full_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks += 1;
            if (got[i] !== want[i]) begin errors++; $display("FAIL full_order[%0d] got=%h exp=%h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] sent[$];
        logic [63:0] got[$];
        int nsent = 0;
        bit take;
        randomize_in();
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && (nsent < 16 || q.size() > 0); cyc++) begin
            out_ready = (cyc % 2 == 0);
            checks += 3;
            if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL b2b_out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, q.size() > 0); end
            if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, q.size() < 2); end
            if (out_data !== exp_data()) begin errors++; $display("FAIL b2b_out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_data()); end
            if (out_valid && out_ready) got.push_back(out_data);
            take = in_valid && (q.size() < 2);
            if (take) sent.push_back(ref_sel(int'(sel), in_data, 4));
            edge_step();
            if (take) begin
                nsent++;
                randomize_in();
                if (nsent == 16) in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        checks += 1;
        if (got.size() != 16 || sent.size() != 16) begin
            errors++; $display("FAIL b2b_count got=%0d sent=%0d exp=16", got.size(), sent.size());
        end
        for (int i = 0; i < got.size() && i < sent.size(); i++) begin
            checks += 1;
            if (got[i] !== sent[i]) begin errors++; $display("FAIL b2b_seq[%0d] got=%h exp=%h", i, got[i], sent[i]); end
        end
    endtask

    task automatic test_nonpow2();
        logic [63:0] lane2;
        reset3 = 1'b1; flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b1; sel3 = 2'd0; in_data3 = '0;
        @(posedge clk); #1;
        reset3 = 1'b0;
        in_data3 = {192{1'b1}}; sel3 = 2'd3; in_valid3 = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (out_valid3 !== 1'b1) begin errors++; $display("FAIL n3_out_valid got=%0b exp=1", out_valid3); end
        if (out_data3 !== 64'h0) begin errors++; $display("FAIL n3_sel3_zero got=%h exp=0", out_data3); end
        lane2 = rnd64();
        in_data3 = {lane2, rnd64(), rnd64()}; sel3 = 2'd2;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        checks += 1;
        if (out_data3 !== ref_sel(2, {64'h0, in_data3}, 3)) begin
            errors++; $display("FAIL n3_sel2 got=%h exp=%h", out_data3, lane2);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        randomize_in(); edge_step();
        randomize_in(); edge_step();
        checks += 1;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull got=%0b exp=0", in_ready); end
        flush = 1'b1; sel = 2'd1; in_data[64 +: 64] = 64'hF1F1_F1F1_F1F1_F1F1;
        edge_step();
        flush = 1'b0; in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        if (out_data !== 64'h0) begin errors++; $display("FAIL flush_out_data got=%h exp=0", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            checks += 1;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost cyc=%0d got=%0b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_reset_flush();
        logic [63:0] marker;
        out_ready = 1'b1; in_valid = 1'b1; reset = 1'b1; flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            randomize_in();
            edge_step();
            checks += 2;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_out_valid cyc=%0d got=%0b exp=0", i, out_valid); end
            if (out_data !== 64'h0) begin errors++; $display("FAIL rf_out_data cyc=%0d got=%h exp=0", i, out_data); end
        end
        reset = 1'b0; flush = 1'b0;
        randomize_in(); marker = rnd64(); sel = 2'd2; in_data[128 +: 64] = marker;
        edge_step();
        in_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rf_first_valid got=%0b exp=1", out_valid); end
        if (out_data !== marker) begin errors++; $display("FAIL rf_first_data got=%h exp=%h", out_data, marker); end
        edge_step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = '0; in_data = '0;
        reset3 = 1'b1; flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; sel3 = '0; in_data3 = '0;
        last = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_nonpow2();
        test_flush();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
